multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Sequencing controller for the multi-cycle MIPS datapath.
- Splits each instruction into FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK steps, so one ALU and one unified memory serve all steps.
- Decodes the latched instruction opcode and drives every datapath mux, write-enable and memory strobe.
- Waits on a memory ready handshake and provides a memory-timeout watchdog.

Parameters:
- MEM_TIMEOUT, 15: maximum cycles a memory state waits for mem_ready before aborting (1..255).
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high; sampled on posedge clock.
- Opcode  input  6  Instruction[31:26] from the instruction register.
- mem_ready  input  1  memory has completed the current read or write this cycle.
- PCWrite  output  1  unconditional PC load.
- PCWriteCond  output  1  PC load if ALU Zero (beq).
- IorD  output  1  0 = memory address from PC, 1 = from ALUOut.
- MemRead  output  1  memory read strobe.
- MemWrite  output  1  memory write strobe.
- IRWrite  output  1  instruction register load.
- MemToReg  output  1  register write data: 0 = ALUOut, 1 = MDR.
- PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- ALUOp  output  2  00 = add, 01 = sub, 10 = funct field.
- ALUSrcA  output  1  0 = PC, 1 = register A.
- ALUSrcB  output  2  00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- RegWrite  output  1  register file write enable.
- RegDst  output  1  destination register: 0 = rt, 1 = rd.
- state  output  4  current state encoding, for debug.
- illegal_op  output  1  one-cycle pulse on an unsupported opcode.
- mem_timeout  output  1  sticky flag; set on watchdog expiry, cleared only by reset.

Behaviour:
- State encoding:
  - FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, R_WB=7, BRANCH=8, JUMP=9.
  - ADDI_EXEC=10 and ADDI_WB=11 exist only with the optional feature.
- Reset:
  - state=FETCH, wait counter=0, illegal_op=0, mem_timeout=0.
  - Reset mid-instruction abandons the instruction; no write enable is asserted in the reset cycle.
- Output style: outputs are combinational from state, with the listed terms gated by mem_ready. Any output not listed for a state is 0.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite are asserted only while mem_ready=1.
  - Goes to DECODE on mem_ready; otherwise stays.
  - At reset, outputs therefore show MemRead=1, ALUSrcB=01, and IRWrite/PCWrite following mem_ready.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - Next state by Opcode: 100011 (lw) or 101011 (sw) -> MEM_ADDR; 000000 -> EXECUTE; 000100 -> BRANCH; 000010 -> JUMP.
  - Any other opcode -> FETCH with illegal_op=1 for exactly the next cycle.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: MemRead=1, IorD=1. Goes to MEM_WB on mem_ready.
- MEM_WB: RegWrite=1, MemToReg=1, RegDst=0. Goes to FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Goes to FETCH on mem_ready.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to R_WB.
- R_WB: RegWrite=1, MemToReg=0, RegDst=1. Goes to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Goes to FETCH.
- JUMP: PCWrite=1, PCSource=10. Goes to FETCH.
- Latency in cycles, assuming mem_ready=1 immediately:
  - R-type 4, lw 5, sw 4, beq 3, j 3.
- Watchdog:
  - Applies in FETCH, MEM_READ and MEM_WRITE.
  - The wait counter clears on state entry and increments each cycle mem_ready=0.
  - When the count reaches MEM_TIMEOUT with mem_ready still 0: mem_timeout is set and state -> FETCH.
  - No strobe (IRWrite, PCWrite, RegWrite, MemWrite) is asserted in the abort cycle.
- Simultaneous events:
  - mem_ready=1 in the same cycle the count reaches MEM_TIMEOUT: treated as success, no timeout.
  - reset has priority over all state transitions.

Optional Feature:
- Macro: MC_ADDI_EN.
- Defined: opcode 001000 in DECODE -> ADDI_EXEC, then ADDI_WB, then FETCH.
  - ADDI_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - ADDI_WB: RegWrite=1, MemToReg=0, RegDst=0.
  - addi latency is 4 cycles.
- Undefined: 001000 is illegal; illegal_op pulses and the FSM returns to FETCH. States 10 and 11 are unreachable.

Test Plan:
- Reset, then Opcode=000000 with mem_ready=1 -> state sequence 0,1,6,7,0; RegWrite=1 and RegDst=1 only in state 7; PCWrite=1 only in state 0.
- Opcode=100011 with mem_ready low for 3 cycles in MEM_READ -> state sequence 0,1,2,3,3,3,3,4,0; MemToReg=1 in state 4; mem_timeout stays 0.
- Opcode=101011 and 000100 -> MemWrite=1 only in state 5; PCWriteCond=1, ALUOp=01, PCSource=01 in state 8.
- Opcode=111111 -> state 0,1,0; illegal_op high for exactly 1 cycle; no RegWrite or MemWrite asserted.
- mem_ready held 0 in FETCH with MEM_TIMEOUT=15 -> mem_timeout rises after 15 wait cycles, IRWrite is never asserted, state returns to FETCH; assert reset -> mem_timeout=0 and state=0 on the next edge.
- Opcode=001000 -> with MC_ADDI_EN: states 0,1,10,11,0, RegWrite=1 with RegDst=0 in state 11. Without MC_ADDI_EN: illegal_op pulse and return to state 0.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS sequencing controller with mem_ready handshake and memory watchdog.
// Define MC_ADDI_EN to add the addi (opcode 001000) execute/writeback path.
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemToReg,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [3:0] state,
  output logic       illegal_op,
  output logic       mem_timeout
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXECUTE   = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9
`ifdef MC_ADDI_EN
    ,
    ADDI_EXEC = 4'd10,
    ADDI_WB   = 4'd11
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_ADDI_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif
  // Abort happens in the MEM_TIMEOUT-th consecutive wait cycle, so compare against count-1.
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           cur_state;
  state_t           next_state;
  logic [CNT_W-1:0] wait_cnt;
  logic             watched;
  logic             abort;
  logic             decode_illegal;

  assign state   = cur_state;
  assign watched = (cur_state == FETCH) || (cur_state == MEM_READ) || (cur_state == MEM_WRITE);
  assign abort   = watched && !mem_ready && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      cur_state   <= FETCH;
      wait_cnt    <= '0;
      illegal_op  <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      cur_state  <= next_state;
      illegal_op <= decode_illegal;
      if (abort)
        mem_timeout <= 1'b1;
      if (abort || (next_state != cur_state))
        wait_cnt <= '0;
      else if (watched && !mem_ready)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    next_state     = cur_state;
    decode_illegal = 1'b0;
    PCWrite        = 1'b0;
    PCWriteCond    = 1'b0;
    IorD           = 1'b0;
    MemRead        = 1'b0;
    MemWrite       = 1'b0;
    IRWrite        = 1'b0;
    MemToReg       = 1'b0;
    PCSource       = 2'b00;
    ALUOp          = 2'b00;
    ALUSrcA        = 1'b0;
    ALUSrcB        = 2'b00;
    RegWrite       = 1'b0;
    RegDst         = 1'b0;
    case (cur_state)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        if (mem_ready) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          next_state = DECODE;
        end
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (Opcode)
          OP_LW, OP_SW: next_state = MEM_ADDR;
          OP_RTYPE:     next_state = EXECUTE;
          OP_BEQ:       next_state = BRANCH;
          OP_J:         next_state = JUMP;
`ifdef MC_ADDI_EN
          OP_ADDI:      next_state = ADDI_EXEC;
`endif
          default: begin
            next_state     = FETCH;
            decode_illegal = 1'b1;
          end
        endcase
      end
      MEM_ADDR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        next_state = (Opcode == OP_SW) ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready)
          next_state = MEM_WB;
        else if (abort)
          next_state = FETCH;
      end
      MEM_WB: begin
        RegWrite   = 1'b1;
        MemToReg   = 1'b1;
        next_state = FETCH;
      end
      MEM_WRITE: begin
        MemWrite = !abort;
        IorD     = 1'b1;
        if (mem_ready || abort)
          next_state = FETCH;
      end
      EXECUTE: begin
        ALUSrcA    = 1'b1;
        ALUOp      = 2'b10;
        next_state = R_WB;
      end
      R_WB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        next_state = FETCH;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        next_state  = FETCH;
      end
      JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        next_state = FETCH;
      end
`ifdef MC_ADDI_EN
      ADDI_EXEC: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        next_state = ADDI_WB;
      end
      ADDI_WB: begin
        RegWrite   = 1'b1;
        next_state = FETCH;
      end
`endif
      default: next_state = FETCH;
    endcase
    // An instruction abandoned by reset must not commit anything.
    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IRWrite     = 1'b0;
      MemWrite    = 1'b0;
      RegWrite    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: instruction-level model builds the expected per-cycle trace.
module tb_multicycle_control_fsm;

  localparam int TO = 15;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] Opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg;
  logic [1:0] PCSource, ALUOp, ALUSrcB;
  logic       ALUSrcA, RegWrite, RegDst;
  logic [3:0] state;
  logic       illegal_op, mem_timeout;

  int  checks = 0;
  int  errors = 0;
  bit  exp_timeout = 1'b0;
  bit  exp_illegal = 1'b0;

  multicycle_control_fsm #(.MEM_TIMEOUT(TO), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .Opcode(Opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemToReg(MemToReg), .PCSource(PCSource),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
    .RegDst(RegDst), .state(state), .illegal_op(illegal_op), .mem_timeout(mem_timeout)
  );

  always #5 clock = ~clock;

  function automatic bit legal(input logic [5:0] op);
    bit ok;
    ok = (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
         (op == 6'b000100) || (op == 6'b000010);
`ifdef MC_ADDI_EN
    ok = ok || (op == 6'b001000);
`endif
    return ok;
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Control word table: {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemToReg,PCSource,ALUOp,ALUSrcA,ALUSrcB,RegWrite,RegDst}
  function automatic logic [15:0] exp_ctrl(input int st, input bit rdy, input bit abt, input bit rst);
    logic pcw, pcwc, iord, memr, memw, irw, m2r, srca, regw, rdst;
    logic [1:0] pcsrc, aluop, srcb;
    {pcw, pcwc, iord, memr, memw, irw, m2r, srca, regw, rdst} = '0;
    {pcsrc, aluop, srcb} = '0;
    case (st)
      0:  begin memr = 1; srcb = 2'b01; pcw = rdy; irw = rdy; end
      1:  srcb = 2'b11;
      2:  begin srca = 1; srcb = 2'b10; end
      3:  begin memr = 1; iord = 1; end
      4:  begin regw = 1; m2r = 1; end
      5:  begin memw = !abt; iord = 1; end
      6:  begin srca = 1; aluop = 2'b10; end
      7:  begin regw = 1; rdst = 1; end
      8:  begin srca = 1; aluop = 2'b01; pcwc = 1; pcsrc = 2'b01; end
      9:  begin pcw = 1; pcsrc = 2'b10; end
      10: begin srca = 1; srcb = 2'b10; end
      11: regw = 1;
      default: ;
    endcase
    if (rst) {pcw, pcwc, irw, memw, regw} = '0;
    return {pcw, pcwc, iord, memr, memw, irw, m2r, pcsrc, aluop, srca, srcb, regw, rdst};
  endfunction

  task automatic checkOutput(input int st, input bit rdy, input bit abt, input string tag);
    logic [15:0] act, expv;
    act  = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
            PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst};
    expv = exp_ctrl(st, rdy, abt, reset);
    checks++;
    assert (state === 4'(st)) else begin
      errors++;
      $error("[TB] FAIL %s state observed=%0d expected=%0d", tag, state, st);
    end
    checks++;
    assert (act === expv) else begin
      errors++;
      $error("[TB] FAIL %s ctrl(st=%0d) observed=%b expected=%b", tag, st, act, expv);
    end
    checks++;
    assert (illegal_op === exp_illegal) else begin
      errors++;
      $error("[TB] FAIL %s illegal_op observed=%b expected=%b", tag, illegal_op, exp_illegal);
    end
    checks++;
    assert (mem_timeout === exp_timeout) else begin
      errors++;
      $error("[TB] FAIL %s mem_timeout observed=%b expected=%b", tag, mem_timeout, exp_timeout);
    end
  endtask

  // One cycle: drive mem_ready, check mid-cycle, then advance the model past the edge.
  task automatic applyStimulus(input int st, input bit rdy, input bit abt, input string tag);
    mem_ready = rdy;
    @(negedge clock);
    checkOutput(st, rdy, abt, tag);
    @(posedge clock);
    if (reset) begin
      exp_timeout = 1'b0;
      exp_illegal = 1'b0;
    end else begin
      if (abt) exp_timeout = 1'b1;
      exp_illegal = (st == 1) && !legal(Opcode);
    end
    #1;
  endtask

  task automatic mem_wait(input int st, input int w, input string tag, output bit ok);
    for (int i = 0; i < w && i < TO; i++) applyStimulus(st, 1'b0, (i == TO - 1), tag);
    ok = (w < TO);
    if (ok) applyStimulus(st, 1'b1, 1'b0, tag);
  endtask

  // Expected trace of one instruction, given its fetch and memory wait lengths.
  task automatic run_instr(input logic [5:0] op, input int wf, input int wm, input string tag);
    bit ok;
    Opcode = op;
    mem_wait(0, wf, tag, ok);
    if (!ok) return;
    applyStimulus(1, rb(), 1'b0, tag);
    if (!legal(op)) return;
    case (op)
      6'b000000: begin applyStimulus(6, rb(), 1'b0, tag); applyStimulus(7, rb(), 1'b0, tag); end
      6'b100011: begin
        applyStimulus(2, rb(), 1'b0, tag);
        mem_wait(3, wm, tag, ok);
        if (ok) applyStimulus(4, rb(), 1'b0, tag);
      end
      6'b101011: begin applyStimulus(2, rb(), 1'b0, tag); mem_wait(5, wm, tag, ok); end
      6'b000100: applyStimulus(8, rb(), 1'b0, tag);
      6'b000010: applyStimulus(9, rb(), 1'b0, tag);
      default:   begin applyStimulus(10, rb(), 1'b0, tag); applyStimulus(11, rb(), 1'b0, tag); end
    endcase
  endtask

  initial begin
    logic [5:0] ops [8];
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000, 6'b111111, 6'b000000};

    reset = 1'b1;
    Opcode = 6'b000000;
    mem_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    applyStimulus(0, 1'b1, 1'b0, "reset");
    reset = 1'b0;

    run_instr(6'b000000, 0, 0, "rtype");
    run_instr(6'b100011, 0, 3, "lw_wait3");
    run_instr(6'b101011, 0, 0, "sw");
    run_instr(6'b000100, 0, 0, "beq");
    run_instr(6'b000010, 2, 0, "j_fwait");
    run_instr(6'b111111, 0, 0, "illegal");
    run_instr(6'b001000, 0, 0, "addi");
    run_instr(6'b000000, TO - 1, 0, "fetch_edge_ok");
    run_instr(6'b100011, 0, TO - 1, "lw_edge_ok");

    Opcode = 6'b000000;
    applyStimulus(0, 1'b1, 1'b0, "rst_mid");
    applyStimulus(1, 1'b0, 1'b0, "rst_mid");
    applyStimulus(6, 1'b1, 1'b0, "rst_mid");
    reset = 1'b1;
    applyStimulus(7, 1'b1, 1'b0, "rst_mid_cycle");
    reset = 1'b0;

    run_instr(6'b000000, TO + 2, 0, "fetch_timeout");
    run_instr(6'b000010, 0, 0, "timeout_sticky");
    run_instr(6'b101011, 0, TO, "sw_timeout");
    reset = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, "timeout_reset");
    reset = 1'b0;
    run_instr(6'b000100, 0, 0, "after_reset");

    for (int n = 0; n < 60; n++) begin
      int sel, wf, wm;
      logic [5:0] op;
      sel = $urandom_range(0, 7);
      op  = (sel == 7) ? 6'($urandom_range(0, 63)) : ops[sel];
      wf  = ($urandom_range(0, 9) == 0) ? $urandom_range(TO, TO + 3) : $urandom_range(0, 3);
      wm  = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 1, TO + 3) : $urandom_range(0, 3);
      run_instr(op, wf, wm, "random");
    end
    applyStimulus(0, 1'b0, 1'b0, "final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
